// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared definitions for the psum drain stage.
//   - default parameter constants
//   - clog2 helper
//   - drain FSM state enum
//   - signed saturation helpers (value and hit flag), width given at call time
package psum_drain_pkg;

   localparam int DEF_BW2   = 16;
   localparam int DEF_OW    = 8;
   localparam int DEF_K     = 4;
   localparam int DEF_SHIFT = 4;
   localparam int DEF_DEPTH = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r++;
      return r;
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   // Clamp v into the signed w-bit range.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

   // True when v lies outside the signed w-bit range.
   function automatic logic sat_hit(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (v > hi) || (v < lo);
   endfunction

endpackage

// File: rtl/psum_drain_if.sv
// psum_drain_if: input beat stream and output result stream of psum_drain.
// Signal names are from the drain block's point of view.
//   i_valid/o_ready/i_psum : psum beats from the PE chain
//   o_valid/i_ready/o_data : results to the consumer (FIFO head)
// Modports: slave = drain block, master = driver/consumer side.
interface psum_drain_if #(
   parameter int BW2 = 16,
   parameter int OW  = 8
);
   logic                  i_valid;
   logic                  o_ready;
   logic signed [BW2-1:0] i_psum;
   logic                  o_valid;
   logic                  i_ready;
   logic signed [OW-1:0]  o_data;

   modport slave  (input  i_valid, i_psum, i_ready,
                   output o_ready, o_valid, o_data);
   modport master (output i_valid, i_psum, i_ready,
                   input  o_ready, o_valid, o_data);
endinterface

// File: rtl/psum_fifo.sv
// psum_fifo: DEPTH-entry first-word-fall-through FIFO for drain results.
// Ports:
//   i_clk, i_rst       clock, async active-high reset (empties the FIFO)
//   i_push, i_data     write request / data (ignored when full)
//   i_pop              read request (ignored when empty)
//   o_data             head entry, 0 when empty
//   o_count            occupancy 0..DEPTH
//   o_full, o_empty    status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module psum_fifo
   import psum_drain_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic [clog2(DEPTH):0]    o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PW = clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [PW:0]  r_wr;
   logic [PW:0]  r_rd;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_count   = r_wr - r_rd;
   assign o_full    = (o_count == (PW+1)'(DEPTH));
   assign o_empty   = (o_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_data    = o_empty ? '0 : r_mem[r_rd[PW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[PW-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + (PW+1)'(1);
         if (w_do_pop)  r_rd <= r_rd + (PW+1)'(1);
      end
   end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: sums K consecutive psum beats into one output element, then
// rounds, arithmetic-shifts by SHIFT, saturates to OW bits and (optionally)
// ReLU-clamps; results queue in a FWFT FIFO for a valid/ready consumer.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   s_bus         psum_drain_if.slave (beat input, result output)
//   o_ovf         sticky saturation flag, cleared only by reset
// Build option: define PSUM_DRAIN_RELU_EN to replace negative results by 0
// (o_ovf still reports saturation only).
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | no beats of the current group held (cnt=0, acc=0)
// ST_ACC  | 0 < cnt < K beats of the current group summed in acc
module psum_drain
   import psum_drain_pkg::*;
#(
   parameter int BW2   = DEF_BW2,
   parameter int OW    = DEF_OW,
   parameter int K     = DEF_K,
   parameter int SHIFT = DEF_SHIFT,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic         i_clk,
   input  logic         i_rst,
   psum_drain_if.slave  s_bus,
   output logic         o_ovf
);
   localparam int CK = clog2(K);
   localparam int AW = BW2 + CK;
   localparam int CW = (CK > 0) ? CK : 1;
   localparam int PW = clog2(DEPTH);
   // One extra bit so the rounding add cannot wrap.
   localparam int WW = AW + 1;
   localparam logic signed [WW-1:0] RND =
      (SHIFT > 0) ? (WW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic signed [AW-1:0]  r_acc;
   logic                  r_ovf;

   logic signed [AW-1:0]  w_psum_ext;
   logic signed [AW-1:0]  w_acc_cur;
   logic signed [AW-1:0]  w_sum;
   logic signed [WW-1:0]  w_round;
   logic signed [WW-1:0]  w_shift;
   logic                  w_sat;
   logic signed [OW-1:0]  w_res;
   logic                  w_final;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic [OW-1:0]         w_fifo_data;
   logic [PW:0]           w_count;
   logic                  w_full;
   logic                  w_empty;

   assign w_psum_ext = AW'(signed'(s_bus.i_psum));
   assign w_acc_cur  = (r_state == ST_IDLE) ? '0 : r_acc;
   assign w_sum      = w_acc_cur + w_psum_ext;
   assign w_round    = WW'(w_sum) + RND;
   assign w_shift    = w_round >>> SHIFT;
   assign w_sat      = sat_hit(64'(w_shift), OW);

`ifdef PSUM_DRAIN_RELU_EN
   logic signed [OW-1:0] w_clip;
   assign w_clip = OW'(sat_to(64'(w_shift), OW));
   assign w_res  = w_clip[OW-1] ? '0 : w_clip;
`else
   assign w_res  = OW'(sat_to(64'(w_shift), OW));
`endif

   // Ready comes from the occupancy alone; a same-cycle pop does not help.
   assign s_bus.o_ready = ~i_rst & (w_count < (PW+1)'(DEPTH));
   assign w_accept      = s_bus.i_valid & s_bus.o_ready;
   assign w_final       = (r_cnt == CW'(K - 1));
   assign w_push        = w_accept & w_final & ~w_full;
   assign w_pop         = ~w_empty & s_bus.i_ready;

   assign s_bus.o_valid = ~w_empty;
   assign s_bus.o_data  = w_fifo_data;
   assign o_ovf         = r_ovf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         if (w_final) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            if (w_sat) r_ovf <= 1'b1;
         end else begin
            r_state <= ST_ACC;
            r_cnt   <= r_cnt + CW'(1);
            r_acc   <= w_sum;
         end
      end
   end

   psum_fifo #(
      .W     (OW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (w_res),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios plus randomized traffic for psum_drain,
// checked every cycle against a queue-based reference model.
module tb_psum_drain;
   localparam int BW2   = 16;
   localparam int OW    = 8;
   localparam int K     = 4;
   localparam int SHIFT = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic ovf;

   always #5 clk = ~clk;

   psum_drain_if #(.BW2(BW2), .OW(OW)) bus ();

   psum_drain #(
      .BW2(BW2), .OW(OW), .K(K), .SHIFT(SHIFT), .DEPTH(DEPTH)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .s_bus (bus),
      .o_ovf (ovf)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: beats of the open group, queued results, sticky flag.
   int grp[$];
   int res_q[$];
   bit m_ovf;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   // Result of one finished group from its plain integer sum.
   function automatic int ref_result(input longint s, output bit sat);
      longint r;
      longint hi;
      longint lo;
      hi  = (longint'(1) <<< (OW - 1)) - 1;
      lo  = -(longint'(1) <<< (OW - 1));
      r   = s + ((SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : 0);
      r   = r >>> SHIFT;
      sat = 1'b0;
      if (r > hi) begin r = hi; sat = 1'b1; end
      else if (r < lo) begin r = lo; sat = 1'b1; end
`ifdef PSUM_DRAIN_RELU_EN
      if (r < 0) r = 0;
`endif
      return int'(r);
   endfunction

   // One clock cycle: drive, check outputs against the model, advance the model.
   task automatic step(input bit v, input int p, input bit rdy);
      bit     acc;
      bit     pop;
      bit     sat;
      longint s;
      int     res;
      @(negedge clk);
      bus.i_valid = v;
      bus.i_psum  = p[BW2-1:0];
      bus.i_ready = rdy;
      #1;
      check_val("o_ready", int'(bus.o_ready), int'(res_q.size() < DEPTH));
      check_val("o_valid", int'(bus.o_valid), int'(res_q.size() > 0));
      check_val("o_data",  int'(bus.o_data),  (res_q.size() > 0) ? res_q[0] : 0);
      check_val("o_ovf",   int'(ovf),         int'(m_ovf));
      acc = v && (res_q.size() < DEPTH);
      pop = (res_q.size() > 0) && rdy;
      if (pop) void'(res_q.pop_front());
      if (acc) begin
         grp.push_back(p);
         if (grp.size() == K) begin
            s = 0;
            foreach (grp[i]) s += grp[i];
            res = ref_result(s, sat);
            res_q.push_back(res);
            if (sat) m_ovf = 1'b1;
            grp.delete();
         end
      end
   endtask

   task automatic group(input int p, input bit rdy);
      for (int i = 0; i < K; i++) step(1'b1, p, rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      #1;
      check_val("rst_o_ready", int'(bus.o_ready), 0);
      check_val("rst_o_valid", int'(bus.o_valid), 0);
      check_val("rst_o_data",  int'(bus.o_data),  0);
      check_val("rst_o_ovf",   int'(ovf),         0);
      grp.delete();
      res_q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int p;
      bit v;
      bit r;
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_psum  = '0;
      bus.i_ready = 1'b0;
      do_reset();

      // basic group: 160 -> 10
      step(1, 16, 1); step(1, 32, 1); step(1, 48, 1); step(1, 64, 1);
      step(0, 0, 1);
      // saturation, then normal groups with sticky ovf
      group(1000, 1); step(0, 0, 1);
      group(16, 1);   step(0, 0, 1);
      // negative with rounding
      group(-16, 1);  step(0, 0, 1); step(0, 0, 1);

      // backpressure: five groups offered with consumer stalled, then drain
      do_reset();
      for (int i = 0; i < 5 * K; i++) step(1, 16, 0);
      for (int i = 0; i < 12; i++) step(1, 16, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1);

      // reset in the middle of a group
      step(1, 100, 1); step(1, 100, 1);
      do_reset();
      group(16, 1);
      step(0, 0, 1); step(0, 0, 1);

      // push and pop in the same cycle at count 3
      for (int i = 0; i < 3; i++) group(16 * (i + 1), 0);
      step(1, -40, 0); step(1, 7, 0); step(1, 300, 0);
      step(1, 500, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 9) < 5);
         if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 400)) - 200;
         else                            p = int'($urandom_range(0, 65535)) - 32768;
         step(v, p, r);
         if (i == 1500) do_reset();
      end
      for (int i = 0; i < 8; i++) step(0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
